branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
//  Sequences the ID-stage branch datapath: holds decode while branch operands are
//  pending, issues the PC redirect for taken branches and jumps, and squashes
//  wrong-path IF/ID slots. Sits between decode/hazard unit, branch compare/target
//  logic and the fetch unit. Also flags misaligned targets and keeps branch statistics.
// PARAMETERS
//  DATA_WIDTH    32  width of jump_address / pc_redirect_addr
//  FLUSH_CYCLES  1   IF/ID squash cycles after redirect handshake (>=1)
//  CNT_WIDTH     16  width of saturating statistics counters
// PORTS
//  clk               in   1           clock
//  rst               in   1           reset, synchronous, active-high
//  clk_en            in   1           global clock enable; low freezes all state
//  id_valid          in   1           valid instruction in ID
//  cbranch_decoded   in   1           conditional branch in ID
//  ubranch_decoded   in   1           JAL/JALR in ID
//  opnd_hazard       in   1           a used branch source is not yet forwardable
//  branch_taken      in   1           compare result for instruction in ID
//  jump_address      in   DATA_WIDTH  computed target
//  imem_ready        in   1           fetch unit accepts redirect this cycle
//  id_stall          out  1           hold PC and IF/ID (combinational)
//  pc_redirect_valid out  1           redirect request (registered)
//  pc_redirect_addr  out  DATA_WIDTH  redirect target (registered)
//  if_id_flush       out  1           squash IF/ID slot (combinational from state)
//  misalign_exc      out  1           1-cycle pulse: taken target[1:0] != 0
//  cnt_branch        out  CNT_WIDTH   resolved branches, saturating
//  cnt_taken         out  CNT_WIDTH   redirected branches, saturating
// BEHAVIOUR
//  Reset (rst=1 at clk edge, regardless of clk_en): state=IDLE, pc_redirect_valid=0,
//   pc_redirect_addr=0, misalign_exc=0, counters=0, flush counter=0.
//  clk_en=0: no register updates; id_stall, if_id_flush still decoded from held state.
//  br = id_valid & (cbranch_decoded | ubranch_decoded). States IDLE, OPND_WAIT, REDIRECT, FLUSH.
//  IDLE: br & opnd_hazard -> OPND_WAIT, id_stall=1 same cycle.
//   br & !hazard & branch_taken & jump_address[1:0]!=0 -> misalign_exc=1 next cycle,
//    cnt_branch++, no redirect, stay IDLE.
//   br & !hazard & branch_taken & aligned -> pc_redirect_addr<=jump_address,
//    pc_redirect_valid<=1, cnt_branch++, cnt_taken++, -> REDIRECT.
//   br & !hazard & !branch_taken -> cnt_branch++, stay IDLE. Non-branch: no action.
//  OPND_WAIT: id_stall=1; re-evaluates IDLE rules each cycle once opnd_hazard=0
//   (resolution in that cycle, id_stall=0); id_valid drop -> IDLE, no count.
//  REDIRECT: pc_redirect_valid=1, addr held stable; if_id_flush=1; branch inputs ignored.
//   imem_ready=1 -> valid<=0; FLUSH_CYCLES==1 -> IDLE else FLUSH, cnt<=FLUSH_CYCLES-1.
//  FLUSH: if_id_flush=1, cnt decrements; IDLE when cnt reaches 0 (after decrement).
//  Latency: taken resolve at cycle N -> pc_redirect_valid at N+1; min 1 handshake cycle.
//  Counters saturate at all-ones, never wrap. Both increment in the same cycle for a taken branch.
//  Reset mid-REDIRECT: valid drops at the reset edge; no pending redirect survives.
//  opnd_hazard with a non-branch: ignored (hazard unit owns non-branch stalls).
// TESTING
//  BEQ taken, no hazard, jump_address=0x0000_0100, imem_ready=1 -> valid=1 @N+1,
//   addr=0x100, if_id_flush @N+1 only, cnt_branch=1, cnt_taken=1.
//  BNE with opnd_hazard high 3 cycles then taken -> id_stall=1 for 3 cycles,
//   redirect the cycle after the hazard clears.
//  JAL taken, imem_ready low 4 cycles -> valid and addr stable 5 cycles, flush held,
//   FLUSH_CYCLES=2 -> one extra flush cycle after handshake.
//  JALR to 0x0000_0102 -> misalign_exc pulse 1 cycle, no redirect, cnt_taken unchanged.
//  Force cnt_taken=0xFFFE, issue 3 taken branches -> stops at 0xFFFF.
//  rst asserted in REDIRECT with clk_en=0 -> IDLE, valid=0, counters 0 next cycle.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// ID-stage branch sequencer: stalls decode on pending branch operands, issues the
// registered PC redirect for taken branches, squashes wrong-path IF/ID slots.
module branch_redirect_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  id_valid,
  input  logic                  cbranch_decoded,
  input  logic                  ubranch_decoded,
  input  logic                  opnd_hazard,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] jump_address,
  input  logic                  imem_ready,
  output logic                  id_stall,
  output logic                  pc_redirect_valid,
  output logic [DATA_WIDTH-1:0] pc_redirect_addr,
  output logic                  if_id_flush,
  output logic                  misalign_exc,
  output logic [CNT_WIDTH-1:0]  cnt_branch,
  output logic [CNT_WIDTH-1:0]  cnt_taken
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPND_WAIT,
    S_REDIRECT,
    S_FLUSH
  } state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  misalign_q, misalign_d;
  logic [FC_W-1:0]       fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0]  cnt_branch_q, cnt_branch_d;
  logic [CNT_WIDTH-1:0]  cnt_taken_q, cnt_taken_d;

  logic br;
  logic resolving;
  logic misaligned;
  logic inc_branch;
  logic inc_taken;

  assign br         = id_valid & (cbranch_decoded | ubranch_decoded);
  assign misaligned = jump_address[1:0] != 2'b00;
  assign resolving  = ((state_q == S_IDLE) || (state_q == S_OPND_WAIT)) & br & ~opnd_hazard;

  assign id_stall    = ((state_q == S_IDLE) || (state_q == S_OPND_WAIT)) & br & opnd_hazard;
  assign if_id_flush = (state_q == S_REDIRECT) || (state_q == S_FLUSH);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    misalign_d = 1'b0;
    fcnt_d     = fcnt_q;
    inc_branch = 1'b0;
    inc_taken  = 1'b0;

    unique case (state_q)
      S_IDLE, S_OPND_WAIT: begin
        // OPND_WAIT falls back to IDLE when the branch leaves ID without resolving.
        state_d = S_IDLE;
        if (br && opnd_hazard) begin
          state_d = S_OPND_WAIT;
        end else if (resolving) begin
          inc_branch = 1'b1;
          if (branch_taken) begin
            if (misaligned) begin
              misalign_d = 1'b1;
            end else begin
              addr_d    = jump_address;
              valid_d   = 1'b1;
              inc_taken = 1'b1;
              state_d   = S_REDIRECT;
            end
          end
        end
      end

      S_REDIRECT: begin
        if (imem_ready) begin
          valid_d = 1'b0;
          if (FLUSH_CYCLES == 1) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
          end
        end
      end

      S_FLUSH: begin
        fcnt_d = fcnt_q - FC_W'(1);
        if (fcnt_q <= FC_W'(1)) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_branch_d = (inc_branch && (cnt_branch_q != '1)) ? cnt_branch_q + CNT_WIDTH'(1)
                                                             : cnt_branch_q;
  assign cnt_taken_d  = (inc_taken && (cnt_taken_q != '1))   ? cnt_taken_q + CNT_WIDTH'(1)
                                                             : cnt_taken_q;

  // NOTE: state registers use non-blocking assignments; reset wins over clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      misalign_q   <= 1'b0;
      fcnt_q       <= '0;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
    end else if (clk_en) begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      misalign_q   <= misalign_d;
      fcnt_q       <= fcnt_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
    end
  end

  assign pc_redirect_valid = valid_q;
  assign pc_redirect_addr  = addr_q;
  assign misalign_exc      = misalign_q;
  assign cnt_branch        = cnt_branch_q;
  assign cnt_taken         = cnt_taken_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: the driver queues expected redirect and
// misalign events, a negedge monitor pops and compares them as the DUT produces them.
module tb_branch_redirect_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          id_valid;
  logic          cbranch_decoded;
  logic          ubranch_decoded;
  logic          opnd_hazard;
  logic          branch_taken;
  logic [DW-1:0] jump_address;
  logic          imem_ready;
  logic          id_stall;
  logic          pc_redirect_valid;
  logic [DW-1:0] pc_redirect_addr;
  logic          if_id_flush;
  logic          misalign_exc;
  logic [CW-1:0] cnt_branch;
  logic [CW-1:0] cnt_taken;

  branch_redirect_ctrl #(
    .DATA_WIDTH  (DW),
    .FLUSH_CYCLES(2),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .id_valid         (id_valid),
    .cbranch_decoded  (cbranch_decoded),
    .ubranch_decoded  (ubranch_decoded),
    .opnd_hazard      (opnd_hazard),
    .branch_taken     (branch_taken),
    .jump_address     (jump_address),
    .imem_ready       (imem_ready),
    .id_stall         (id_stall),
    .pc_redirect_valid(pc_redirect_valid),
    .pc_redirect_addr (pc_redirect_addr),
    .if_id_flush      (if_id_flush),
    .misalign_exc     (misalign_exc),
    .cnt_branch       (cnt_branch),
    .cnt_taken        (cnt_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mis;
    logic [31:0] addr;
    int          cb;
    int          ct;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cb     = 0;
  int   m_ct     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_valid        = 1'b0;
    cbranch_decoded = 1'b0;
    ubranch_decoded = 1'b0;
    opnd_hazard     = 1'b0;
    branch_taken    = 1'b0;
    jump_address    = '0;
    imem_ready      = 1'b1;
  endtask

  task automatic present(input bit cond, input bit haz, input bit tk, input logic [31:0] a);
    id_valid        = 1'b1;
    cbranch_decoded = cond;
    ubranch_decoded = !cond;
    opnd_hazard     = haz;
    branch_taken    = tk;
    jump_address    = a;
  endtask

  task automatic expect_redirect(input logic [31:0] a);
    exp_t e;
    m_cb     = sat(m_cb);
    m_ct     = sat(m_ct);
    e.is_mis = 1'b0;
    e.addr   = a;
    e.cb     = m_cb;
    e.ct     = m_ct;
    exp_q.push_back(e);
  endtask

  task automatic expect_misalign();
    exp_t e;
    m_cb     = sat(m_cb);
    e.is_mis = 1'b1;
    e.addr   = '0;
    e.cb     = m_cb;
    e.ct     = m_ct;
    exp_q.push_back(e);
  endtask

  // Monitor: one pop per redirect handshake or misalign pulse.
  always @(negedge clk) begin
    if (!rst && clk_en && ((pc_redirect_valid && imem_ready) || misalign_exc)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: valid=%0b misalign=%0b addr=0x%0h, expected none",
                 pc_redirect_valid, misalign_exc, pc_redirect_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_is_misalign", 32'(misalign_exc), 32'(e.is_mis));
        if (!e.is_mis) check("redirect_addr", pc_redirect_addr, e.addr);
        check("event_cnt_branch", 32'(cnt_branch), 32'(e.cb));
        check("event_cnt_taken", 32'(cnt_taken), 32'(e.ct));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    clk_en = 1'b1;
    clear_in();
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(pc_redirect_valid), 0);
    check("rst_addr", pc_redirect_addr, 0);
    check("rst_flush", 32'(if_id_flush), 0);
    check("rst_stall", 32'(id_stall), 0);
    check("rst_misalign", 32'(misalign_exc), 0);
    check("rst_cnt_branch", 32'(cnt_branch), 0);
    check("rst_cnt_taken", 32'(cnt_taken), 0);

    // BEQ taken, no hazard, fetch ready immediately.
    present(1, 0, 1, 32'h0000_0100);
    #1;
    check("beq_stall", 32'(id_stall), 0);
    check("beq_flush_n", 32'(if_id_flush), 0);
    check("beq_valid_n", 32'(pc_redirect_valid), 0);
    expect_redirect(32'h0000_0100);
    step();
    clear_in();
    #1;
    check("beq_valid_n1", 32'(pc_redirect_valid), 1);
    check("beq_flush_n1", 32'(if_id_flush), 1);
    step();
    check("beq_valid_drop", 32'(pc_redirect_valid), 0);
    check("beq_flush_extra", 32'(if_id_flush), 1);
    step();
    check("beq_flush_end", 32'(if_id_flush), 0);

    // BNE with operand hazard for 3 cycles, then taken.
    present(1, 1, 1, 32'h0000_0200);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bne_stall", 32'(id_stall), 1);
      check("bne_no_redirect", 32'(pc_redirect_valid), 0);
      step();
    end
    opnd_hazard = 1'b0;
    #1;
    check("bne_stall_clear", 32'(id_stall), 0);
    expect_redirect(32'h0000_0200);
    step();
    clear_in();
    #1;
    check("bne_valid", 32'(pc_redirect_valid), 1);
    check("bne_addr", pc_redirect_addr, 32'h0000_0200);
    step();
    step();

    // JAL taken with fetch back-pressure; a stray branch in ID must be ignored.
    present(0, 0, 1, 32'h0000_0300);
    expect_redirect(32'h0000_0300);
    step();
    present(1, 0, 1, 32'h0000_0998);
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("jal_valid_hold", 32'(pc_redirect_valid), 1);
      check("jal_addr_hold", pc_redirect_addr, 32'h0000_0300);
      check("jal_flush_hold", 32'(if_id_flush), 1);
      step();
    end
    clear_in();
    #1;
    check("jal_valid_hs", 32'(pc_redirect_valid), 1);
    check("jal_addr_hs", pc_redirect_addr, 32'h0000_0300);
    step();
    check("jal_valid_drop", 32'(pc_redirect_valid), 0);
    check("jal_flush_extra", 32'(if_id_flush), 1);
    step();
    check("jal_flush_end", 32'(if_id_flush), 0);
    check("jal_cnt_branch", 32'(cnt_branch), 32'(m_cb));

    // JALR to a misaligned target.
    present(0, 0, 1, 32'h0000_0102);
    expect_misalign();
    step();
    clear_in();
    #1;
    check("jalr_misalign", 32'(misalign_exc), 1);
    check("jalr_no_redirect", 32'(pc_redirect_valid), 0);
    check("jalr_no_flush", 32'(if_id_flush), 0);
    step();
    check("jalr_pulse_end", 32'(misalign_exc), 0);
    check("jalr_cnt_taken", 32'(cnt_taken), 32'(m_ct));

    // Not-taken branch counts; hazard on a non-branch is ignored.
    present(1, 0, 0, 32'h0000_0444);
    m_cb = sat(m_cb);
    step();
    clear_in();
    check("nt_cnt_branch", 32'(cnt_branch), 32'(m_cb));
    check("nt_cnt_taken", 32'(cnt_taken), 32'(m_ct));
    check("nt_no_redirect", 32'(pc_redirect_valid), 0);
    id_valid    = 1'b1;
    opnd_hazard = 1'b1;
    #1;
    check("nonbr_stall", 32'(id_stall), 0);
    step();
    clear_in();

    // Branch leaves ID while waiting on operands: no count.
    present(1, 1, 1, 32'h0000_0500);
    step();
    id_valid = 1'b0;
    #1;
    check("drop_stall", 32'(id_stall), 0);
    step();
    clear_in();
    check("drop_cnt_branch", 32'(cnt_branch), 32'(m_cb));
    check("drop_no_redirect", 32'(pc_redirect_valid), 0);

    // Saturation of both counters.
    for (int i = 0; i < 14; i++) begin
      present(1, 0, 1, 32'h0000_1000 + 32'(i * 4));
      expect_redirect(32'h0000_1000 + 32'(i * 4));
      step();
      clear_in();
      step();
      step();
    end
    check("sat_cnt_branch", 32'(cnt_branch), 32'hF);
    check("sat_cnt_taken", 32'(cnt_taken), 32'hF);

    // Clock enable low: nothing registers, stall still decoded.
    clk_en = 1'b0;
    present(1, 0, 1, 32'h0000_0700);
    step();
    check("frz_no_redirect", 32'(pc_redirect_valid), 0);
    opnd_hazard = 1'b1;
    #1;
    check("frz_stall", 32'(id_stall), 1);
    clk_en = 1'b1;
    clear_in();

    // Reset while in REDIRECT with clk_en low.
    present(0, 0, 1, 32'h0000_0800);
    step();
    clear_in();
    imem_ready = 1'b0;
    #1;
    check("rr_valid_before", 32'(pc_redirect_valid), 1);
    clk_en = 1'b0;
    step();
    check("rr_frozen_valid", 32'(pc_redirect_valid), 1);
    check("rr_frozen_flush", 32'(if_id_flush), 1);
    rst = 1'b1;
    step();
    rst  = 1'b0;
    m_cb = 0;
    m_ct = 0;
    check("rr_valid", 32'(pc_redirect_valid), 0);
    check("rr_addr", pc_redirect_addr, 0);
    check("rr_flush", 32'(if_id_flush), 0);
    check("rr_cnt_branch", 32'(cnt_branch), 0);
    check("rr_cnt_taken", 32'(cnt_taken), 0);
    clk_en = 1'b1;
    clear_in();

    // Normal operation after reset.
    present(1, 0, 1, 32'h0000_0900);
    expect_redirect(32'h0000_0900);
    step();
    clear_in();
    step();
    step();
    step();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
